// File: rtl/naes_pkg.sv
// Shared NES system definitions: OAM DMA state encoding and
// the PPU/APU register addresses that both decoders use.
package naes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_t;

  localparam logic [15:0] PPU_OAMDATA = 16'h2004;
  localparam logic [15:0] OAM_DMA_REG = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: a CPU write to $4014 copies one page into OAMDATA.
// Build option DMA_ODD_ALIGN_EN adds the extra odd-cycle alignment slot.
module oam_dma
  import naes_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_REG,
  parameter logic [15:0] OAMDATA_ADDR = PPU_OAMDATA,
  parameter int          XFER_LEN     = 256
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr,
  input  logic        odd_or_even,
  input  logic [7:0]  mem_rdata,
  output logic        dma_hijack,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_wr,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  dma_state_t state_nx;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       trig;
  logic       align_req;

  assign trig = (bus_addr == TRIGGER_ADDR) && !bus_wr;

`ifdef DMA_ODD_ALIGN_EN
  assign align_req = odd_or_even;
`else
  logic unused_odd;
  assign unused_odd = odd_or_even;
  assign align_req  = 1'b0;
`endif

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == IDLE && trig) begin
        page <= bus_din;
        idx  <= 8'h00;
      end
      if (state == READ) data <= mem_rdata;
      if (state == WRITE) idx <= idx + 8'h01;
    end
  end

  assign dma_dout = data;

  always_comb begin
    state_nx   = state;
    dma_hijack = 1'b0;
    dma_addr   = 16'h0000;
    dma_wr     = 1'b1;
    dma_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) state_nx = HALT;
      end
      HALT: begin
        dma_hijack = 1'b1;
        state_nx   = align_req ? ALIGN : READ;
      end
      ALIGN: begin
        dma_hijack = 1'b1;
        state_nx   = READ;
      end
      READ: begin
        dma_hijack = 1'b1;
        dma_addr   = {page, idx};
        state_nx   = WRITE;
      end
      WRITE: begin
        dma_hijack = 1'b1;
        dma_addr   = OAMDATA_ADDR;
        dma_wr     = 1'b0;
        state_nx   = (idx == LAST_IDX) ? DONE : READ;
      end
      DONE: begin
        dma_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected bus
// traffic, a negedge monitor pops and compares it.
module tb_oam_dma;
  import naes_pkg::*;

`ifdef DMA_ODD_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_rdata;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_done;

  int errors = 0;
  int checks = 0;
  int run    = 0;

  logic [15:0] exp_rd[$];
  logic [7:0]  exp_wr[$];
  int          exp_len[$];

  oam_dma dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_din    (bus_din),
    .bus_wr     (bus_wr),
    .odd_or_even(odd_or_even),
    .mem_rdata  (mem_rdata),
    .dma_hijack (dma_hijack),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_wr     (dma_wr),
    .dma_done   (dma_done)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    if (a[15:8] == 8'hFF) return ~a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always_comb mem_rdata = mem_f(dma_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge cpu_clk) begin
    if (dma_hijack === 1'b1) begin
      run++;
      if (dma_wr === 1'b0) begin
        if (exp_wr.size() == 0) fail_now("unexp_wr");
        else begin
          chk("wr_addr", 32'(dma_addr), 32'(PPU_OAMDATA));
          chk("wr_data", 32'(dma_dout), 32'(exp_wr.pop_front()));
        end
      end else if (dma_addr != 16'h0000) begin
        if (exp_rd.size() == 0) fail_now("unexp_rd");
        else chk("rd_addr", 32'(dma_addr), 32'(exp_rd.pop_front()));
      end
    end else if (run > 0) begin
      if (exp_len.size() == 0) fail_now("unexp_hijack");
      else chk("hijack_len", 32'(run), 32'(exp_len.pop_front()));
      run = 0;
    end
  end

  task automatic bus_idle();
    bus_addr = 16'h0000;
    bus_din  = 8'h00;
    bus_wr   = 1'b1;
  endtask

  task automatic run_dma(input logic [7:0] page, input logic odd,
                         input int inject_at, input int reset_at);
    int n;
    int lat;
    int exp_lat;
    bit got_done;
    n       = (reset_at > 0) ? (reset_at - 1) / 2 : 256;
    exp_lat = (odd && ALIGN_ON == 1) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back({page, 8'(i)});
      exp_wr.push_back(mem_f({page, 8'(i)}));
    end
    if (reset_at > 0) exp_len.push_back(reset_at);
    else exp_len.push_back(513 + ((odd && ALIGN_ON == 1) ? 1 : 0));
    bus_addr    = OAM_DMA_REG;
    bus_din     = page;
    bus_wr      = 1'b0;
    odd_or_even = odd;
    @(posedge cpu_clk);
    #1;
    bus_idle();
    lat      = -1;
    got_done = 1'b0;
    for (int k = 1; k < 700; k++) begin
      @(posedge cpu_clk);
      #1;
      if (lat < 0 && dma_hijack && dma_wr && dma_addr == {page, 8'h00})
        lat = k;
      if (k == inject_at) begin
        bus_addr = OAM_DMA_REG;
        bus_din  = 8'h77;
        bus_wr   = 1'b0;
      end else bus_idle();
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        chk("rst_hijack", 32'(dma_hijack), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        break;
      end
      if (dma_done) begin
        got_done = 1'b1;
        chk("done_hijack", 32'(dma_hijack), 32'd0);
        break;
      end
    end
    odd_or_even = 1'b0;
    if (reset_at == 0) begin
      chk("done_seen", 32'(got_done), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      @(posedge cpu_clk);
      #1;
      chk("done_pulse", 32'(dma_done), 32'd0);
      chk("idle_state", 32'(dut.state), 32'(IDLE));
    end
    repeat (3) @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    odd_or_even = 1'b0;
    bus_idle();
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_hijack0", 32'(dma_hijack), 32'd0);
    chk("rst_addr0", 32'(dma_addr), 32'd0);
    chk("rst_dout0", 32'(dma_dout), 32'd0);
    chk("rst_wr0", 32'(dma_wr), 32'd1);
    chk("rst_done0", 32'(dma_done), 32'd0);
    reset = 1'b0;
    @(posedge cpu_clk);
    #1;

    run_dma(8'h02, 1'b0, 0, 0);
    run_dma(8'h02, 1'b1, 0, 0);
    run_dma(8'hFF, 1'b0, 0, 0);
    run_dma(8'h05, 1'b0, 50, 0);
    run_dma(8'h06, 1'b0, 0, 201);
    run_dma(8'h03, 1'b0, 0, 0);

    bus_addr = OAM_DMA_REG;
    bus_din  = 8'h04;
    bus_wr   = 1'b1;
    @(posedge cpu_clk);
    #1;
    bus_addr = 16'h4015;
    bus_wr   = 1'b0;
    @(posedge cpu_clk);
    #1;
    bus_idle();
    for (int k = 0; k < 4; k++) begin
      @(posedge cpu_clk);
      #1;
      chk("no_trig", 32'(dma_hijack), 32'd0);
    end

    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("len_left", 32'(exp_len.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
